cond_sequencer: RTL
===================

COND_SEQUENCER -- requirements
Module: Cond_Sequencer

Interface
REQ-001 The block SHALL use one clock, i_Clk; reset i_Reset SHALL be synchronous and active-high.
REQ-002 Ports (name  direction  width  meaning):
- i_Clk  in  1  clock.
- i_Reset  in  1  synchronous active-high reset.
- i_Start  in  1  decoded instruction valid; sampled only in IDLE.
- i_Cond  in  4  instruction condition field.
- i_SetFlags  in  1  S-bit.
- i_RegWriteReq  in  1  instruction writes Rd.
- i_MemOp  in  1  load/store.
- i_IsStore  in  1  store (valid when i_MemOp=1).
- i_IsBranch  in  1  branch.
- i_ALUFlags  in  4  NZCV result from ALU, valid in EXECUTE.
- i_MemReady  in  1  memory access complete.
- o_Ready  out  1  IDLE, accepting i_Start.
- o_MemEn  out  1  memory access strobe.
- o_MemWrite  out  1  store strobe.
- o_RegWrite  out  1  register-file write enable.
- o_PCWrite  out  1  PC update enable.
- o_BranchTaken  out  1  PC source = branch target.
- o_Done  out  1  instruction retired, one-cycle pulse.
- o_Squashed  out  1  retired instruction failed its condition.
- o_MemFault  out  1  memory timeout, one-cycle pulse.
- o_CPSR  out  4  architectural NZCV register.
- o_State  out  3  FSM state encoding.

Function
REQ-003 FSM states and encodings SHALL be: IDLE=0, DECODE=1, EXECUTE=2, MEMORY=3, WRITEBACK=4; codes 5-7 SHALL go to IDLE on the next clock.
REQ-004 All strobe outputs SHALL be Moore outputs decoded from state and latched fields only. When a strobe is not listed as asserted for a state, it SHALL be 0.
REQ-005 IDLE: o_Ready=1. When i_Start=1, the block SHALL latch i_Cond, i_SetFlags, i_RegWriteReq, i_MemOp, i_IsStore and i_IsBranch, then go to DECODE. When i_Start=0, it SHALL stay in IDLE.
REQ-006 i_Start SHALL be ignored in every state except IDLE.
REQ-007 DECODE: the block SHALL evaluate the latched condition against o_CPSR using the ARMv7 table:
- EQ Z; NE !Z; CS C; CC !C; MI N; PL !N; VS V; VC !V.
- HI C&!Z; LS !C|Z; GE N==V; LT N!=V; GT !Z&(N==V); LE Z|(N!=V).
- AL 1; 1111 0.
It SHALL latch the result as "pass" and go to EXECUTE.
REQ-008 EXECUTE: if pass=1 and SetFlags=1, o_CPSR SHALL load i_ALUFlags at the clock edge ending EXECUTE. Otherwise o_CPSR SHALL hold.
REQ-009 EXECUTE transition: if pass=1 and MemOp=1, go to MEMORY; otherwise go to WRITEBACK.
REQ-010 MEMORY: o_MemEn=1 and o_MemWrite=IsStore. A 4-bit wait counter SHALL clear on entry and increment each cycle that i_MemReady=0.
REQ-011 MEMORY exit on i_MemReady=1: go to WRITEBACK. This exit SHALL take priority over timeout when both occur in the same cycle.
REQ-012 MEMORY timeout: if the counter reaches 15 with i_MemReady=0, the block SHALL pulse o_MemFault for one cycle, set an internal fault bit and go to WRITEBACK.
REQ-013 WRITEBACK outputs:
- o_Done=1 and o_PCWrite=1.
- o_BranchTaken = pass & IsBranch & !fault.
- o_RegWrite = pass & RegWriteReq & !(MemOp & IsStore) & !fault.
- o_Squashed = !pass.
The block SHALL then go to IDLE and clear the fault bit.
REQ-014 Latency from i_Start sampled (cycle 0) to o_Done:
- non-memory or failed-condition instruction: o_Done in cycle 3.
- memory instruction with i_MemReady high in its first MEMORY cycle: o_Done in cycle 4.
- each additional wait cycle: +1.
REQ-015 A failed condition SHALL suppress CPSR update, memory strobes, o_RegWrite and o_BranchTaken; o_PCWrite SHALL still assert.
REQ-016 Flags written in EXECUTE of instruction k SHALL be visible to the DECODE of instruction k+1.

Reset
REQ-017 While i_Reset=1, the block SHALL set state IDLE, o_CPSR=4'b0000, and clear the wait counter, fault bit, pass and all latched fields.
REQ-018 During reset, o_Ready SHALL be 0 and every other output SHALL be 0. From the first cycle after reset deasserts, outputs SHALL follow REQ-004.
REQ-019 Reset asserted in any state, including mid-MEMORY, SHALL abort the instruction with no o_Done, o_RegWrite or o_MemFault pulse.

Verification
REQ-020 Reset, then i_Start with Cond=1110, SetFlags=1, ALUFlags=0100, RegWriteReq=1 -> o_Done and o_RegWrite in cycle 3; o_CPSR=0100 from cycle 3.
REQ-021 With CPSR=0100, i_Start Cond=0001 (NE), SetFlags=1, ALUFlags=1000 -> o_Squashed=1, o_RegWrite=0, o_PCWrite=1; CPSR stays 0100.
REQ-022 Load with Cond=1110 and i_MemReady low for 3 MEMORY cycles -> o_MemEn high for 4 cycles, o_MemWrite=0, o_RegWrite=1, o_Done in cycle 7.
REQ-023 Store with i_MemReady held 0 -> o_MemFault pulse after 16 MEMORY cycles, then WRITEBACK with o_RegWrite=0 and o_BranchTaken=0.
REQ-024 i_Start pulsed during EXECUTE -> ignored; back-to-back instructions with CPSR N=1, V=0 and Cond=1011 (LT) -> pass; Cond=1010 (GE) -> squashed.
REQ-025 i_Reset asserted in the second MEMORY cycle -> next cycle: state=0, o_CPSR=0000, no o_Done.

Source files
------------

// File: rtl/cond_sequencer.sv
// Multi-cycle conditional-execution sequencer: IDLE -> DECODE -> EXECUTE -> [MEMORY] -> WRITEBACK.
// Owns the architectural NZCV register and evaluates ARM condition codes against it.
module cond_sequencer (
  input  logic       i_Clk,
  input  logic       i_Reset,
  input  logic       i_Start,
  input  logic [3:0] i_Cond,
  input  logic       i_SetFlags,
  input  logic       i_RegWriteReq,
  input  logic       i_MemOp,
  input  logic       i_IsStore,
  input  logic       i_IsBranch,
  input  logic [3:0] i_ALUFlags,
  input  logic       i_MemReady,
  output logic       o_Ready,
  output logic       o_MemEn,
  output logic       o_MemWrite,
  output logic       o_RegWrite,
  output logic       o_PCWrite,
  output logic       o_BranchTaken,
  output logic       o_Done,
  output logic       o_Squashed,
  output logic       o_MemFault,
  output logic [3:0] o_CPSR,
  output logic [2:0] o_State
);

  // state     | meaning
  // IDLE      | ready, waits for i_Start and latches instruction fields
  // DECODE    | evaluates condition against CPSR, latches pass
  // EXECUTE   | optional CPSR update from ALU flags
  // MEMORY    | memory strobe, wait counter with timeout
  // WRITEBACK | retire: done/pcwrite and qualified write enables
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    DECODE    = 3'd1,
    EXECUTE   = 3'd2,
    MEMORY    = 3'd3,
    WRITEBACK = 3'd4
  } state_t;

  state_t     state_q, state_d;
  logic [3:0] cond_q;
  logic       set_flags_q, reg_write_q, mem_op_q, is_store_q, is_branch_q;
  logic       pass_q, fault_q;
  logic [3:0] wait_cnt_q;
  logic [3:0] cpsr_q;
  logic       cond_pass;

  always_comb begin
    logic n, z, c, v;
    {n, z, c, v} = cpsr_q;
    cond_pass = 1'b0;
    case (cond_q)
      4'b0000: cond_pass = z;
      4'b0001: cond_pass = !z;
      4'b0010: cond_pass = c;
      4'b0011: cond_pass = !c;
      4'b0100: cond_pass = n;
      4'b0101: cond_pass = !n;
      4'b0110: cond_pass = v;
      4'b0111: cond_pass = !v;
      4'b1000: cond_pass = c & !z;
      4'b1001: cond_pass = !c | z;
      4'b1010: cond_pass = (n == v);
      4'b1011: cond_pass = (n != v);
      4'b1100: cond_pass = !z & (n == v);
      4'b1101: cond_pass = z | (n != v);
      4'b1110: cond_pass = 1'b1;
      default: cond_pass = 1'b0;
    endcase
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (i_Start) state_d = DECODE;
      DECODE:    state_d = EXECUTE;
      EXECUTE:   state_d = (pass_q && mem_op_q) ? MEMORY : WRITEBACK;
      // Ready beats timeout when both land in the same cycle.
      MEMORY:    if (i_MemReady || wait_cnt_q == 4'd15) state_d = WRITEBACK;
      WRITEBACK: state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      state_q     <= IDLE;
      cond_q      <= 4'd0;
      set_flags_q <= 1'b0;
      reg_write_q <= 1'b0;
      mem_op_q    <= 1'b0;
      is_store_q  <= 1'b0;
      is_branch_q <= 1'b0;
      pass_q      <= 1'b0;
      fault_q     <= 1'b0;
      wait_cnt_q  <= 4'd0;
      cpsr_q      <= 4'd0;
    end else begin
      state_q <= state_d;
      case (state_q)
        IDLE: if (i_Start) begin
          cond_q      <= i_Cond;
          set_flags_q <= i_SetFlags;
          reg_write_q <= i_RegWriteReq;
          mem_op_q    <= i_MemOp;
          is_store_q  <= i_IsStore;
          is_branch_q <= i_IsBranch;
        end
        DECODE: pass_q <= cond_pass;
        EXECUTE: begin
          wait_cnt_q <= 4'd0;
          if (pass_q && set_flags_q) cpsr_q <= i_ALUFlags;
        end
        MEMORY: if (!i_MemReady) begin
          wait_cnt_q <= wait_cnt_q + 4'd1;
          if (wait_cnt_q == 4'd15) fault_q <= 1'b1;
        end
        WRITEBACK: fault_q <= 1'b0;
        default: ;
      endcase
    end
  end

  // Outputs are forced low while reset is held, independent of the current state.
  always_comb begin
    o_Ready       = 1'b0;
    o_MemEn       = 1'b0;
    o_MemWrite    = 1'b0;
    o_RegWrite    = 1'b0;
    o_PCWrite     = 1'b0;
    o_BranchTaken = 1'b0;
    o_Done        = 1'b0;
    o_Squashed    = 1'b0;
    o_MemFault    = 1'b0;
    o_CPSR        = 4'd0;
    o_State       = 3'd0;
    if (!i_Reset) begin
      o_CPSR  = cpsr_q;
      o_State = state_q;
      case (state_q)
        IDLE: o_Ready = 1'b1;
        MEMORY: begin
          o_MemEn    = 1'b1;
          o_MemWrite = is_store_q;
        end
        WRITEBACK: begin
          o_Done        = 1'b1;
          o_PCWrite     = 1'b1;
          o_BranchTaken = pass_q & is_branch_q & !fault_q;
          o_RegWrite    = pass_q & reg_write_q & !(mem_op_q & is_store_q) & !fault_q;
          o_Squashed    = !pass_q;
          o_MemFault    = fault_q;
        end
        default: ;
      endcase
    end
  end

endmodule
